store_buffer: RTL and testbench

- Posted-write buffer between the single-cycle core's data port (MemWrite/DataAdr/WriteData/ReadData) and a data memory with variable write latency.
- Captures each store in one cycle and drains stores in order to memory over a valid/ready handshake.
- Loads are served with store-to-load forwarding, so the core sees its own pending stores.
- Asserts stall when it cannot accept a store.

---
 rtl/store_buffer.sv | 91 +++++++++
 tb/tb_store_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with in-order drain and store-to-load forwarding
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_we,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     stall,
  output logic                     mem_valid,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_raddr,
  input  logic [DW-1:0]            mem_rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign stall     = (count_q == CW'(DEPTH));
  assign mem_valid = (count_q != '0);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign mem_addr  = addr_q[head_q];
  assign mem_wdata = data_q[head_q];
  assign mem_raddr = cpu_addr;

  // A push is refused whenever the registered count is full, even if the head pops this edge.
  assign push = cpu_we & ~stall;
  assign pop  = mem_valid & mem_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; validity is carried by head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_wdata;
    end
  end

  // Walk oldest to youngest so the last word match seen is the youngest pending store.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = head_q;
    cpu_rdata = mem_rdata;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx][AW-1:2] == cpu_addr[AW-1:2]))
        cpu_rdata = data_q[idx];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    count;
  logic          empty;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .stall(stall),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Memory side: record every accepted handshake in arrival order.
  always @(posedge clk) begin
    if (reset && mem_valid && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accepted);
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    if (accepted) expect_store(a, d);
    step();
    cpu_we = 1'b0;
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, 64'(log_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(log_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("%s_data%0d", tag, i), 64'(log_data[i]), 64'(exp_data[i]));
    end
  endtask

  initial begin
    reset     = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD;
    #12;
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    step();
    reset = 1'b1;

    // Single store
    mem_ready = 1'b1;
    push_one(32'h64, 32'd7, 1'b1);
    chk("single_valid", 64'(mem_valid), 64'd1);
    chk("single_addr", 64'(mem_addr), 64'h64);
    chk("single_data", 64'(mem_wdata), 64'd7);
    chk("single_count", 64'(count), 64'd1);
    step();
    chk("single_empty", 64'(empty), 64'd1);
    chk_log("single");

    // Fill and stall
    mem_ready = 1'b0;
    push_one(32'h60, 32'd1, 1'b1);
    push_one(32'h64, 32'd2, 1'b1);
    push_one(32'h68, 32'd3, 1'b1);
    push_one(32'h6C, 32'd4, 1'b1);
    chk("fill_stall", 64'(stall), 64'd1);
    chk("fill_count", 64'(count), 64'd4);
    push_one(32'h70, 32'd5, 1'b0);
    chk("fill_ignored_count", 64'(count), 64'd4);
    chk("fill_head_data", 64'(mem_wdata), 64'd1);
    mem_ready = 1'b1;
    step();
    chk("fill_stall_drop", 64'(stall), 64'd0);
    chk("fill_count3", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) step();
    chk("fill_empty", 64'(empty), 64'd1);
    chk_log("fill");

    // Forwarding youngest
    mem_ready = 1'b0;
    push_one(32'h64, 32'd7, 1'b1);
    push_one(32'h64, 32'd9, 1'b1);
    cpu_addr = 32'h64;
    #1;
    chk("fwd_young", 64'(cpu_rdata), 64'd9);
    chk("fwd_raddr", 64'(mem_raddr), 64'h64);
    cpu_addr = 32'h68;
    #1;
    chk("fwd_miss", 64'(cpu_rdata), 64'hDEAD);
    cpu_addr = 32'h66;
    #1;
    chk("fwd_byteoff", 64'(cpu_rdata), 64'd9);
    mem_ready = 1'b1;
    step();
    step();
    chk("fwd_drained", 64'(empty), 64'd1);
    cpu_addr = 32'h64;
    #1;
    chk("fwd_after_drain", 64'(cpu_rdata), 64'hDEAD);
    chk_log("fwd");

    // Simultaneous push/pop
    mem_ready = 1'b0;
    push_one(32'h100, 32'hA0, 1'b1);
    push_one(32'h104, 32'hA1, 1'b1);
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_one(32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1);
      chk($sformatf("sim_count%0d", i), 64'(count), 64'd2);
    end
    step();
    step();
    chk("sim_empty", 64'(empty), 64'd1);
    chk_log("sim");

    // Full with pop on the same edge
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(32'h300 + 32'(4 * i), 32'hC0 + 32'(i), 1'b1);
    chk("fullpop_stall", 64'(stall), 64'd1);
    mem_ready = 1'b1;
    push_one(32'h3F0, 32'hEE, 1'b0);
    chk("fullpop_count", 64'(count), 64'd3);
    chk("fullpop_stall0", 64'(stall), 64'd0);
    for (int i = 0; i < 3; i++) step();
    chk("fullpop_empty", 64'(empty), 64'd1);
    chk_log("fullpop");

    // Asynchronous reset mid-operation
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(32'h400 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0);
    chk("rstmid_count3", 64'(count), 64'd3);
    chk("rstmid_valid1", 64'(mem_valid), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("rstmid_valid0", 64'(mem_valid), 64'd0);
    chk("rstmid_count0", 64'(count), 64'd0);
    chk("rstmid_stall0", 64'(stall), 64'd0);
    #1;
    reset     = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rstmid_no_issue", 64'(mem_valid), 64'd0);
    chk("rstmid_empty", 64'(empty), 64'd1);
    chk_log("rstmid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
